// File: rtl/data_ram_resp.sv
// data_ram_resp: word-organised data RAM responder for the core's RAM port.
// Accepts one access at a time, inserts WAIT_CYCLES wait states, then completes.
//
// Parameters:
//   ADDR_W      word-index bits; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES extra cycles between acceptance and completion (0..15)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous reset, active high despite its name
//   ce_i     access request (core ram_ce_o)
//   we_i     1 = write, 0 = read
//   addr_i   byte address; bits [ADDR_W+1:2] select the word, upper bits alias
//   sel_i    byte-lane enables, sel_i[0] = data[7:0]
//   data_i   write data
//   data_o   registered read data (core ram_data_i), held until the next read
//   stall_o  stall request to the pipeline controller
//   err_o    alignment-error pulse in the completion cycle
//
// Optional feature: define DRAM_ALIGN_CHK_EN to enable the alignment check.
// When undefined, err_o is tied low and every access follows the lane rules.

module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       stall;

    // Request latched on acceptance; used while waiting.
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;

    // Request as seen by the completion edge. With WAIT_CYCLES=0 the
    // accepting edge is also the completing edge, so the live inputs
    // must be used directly instead of the latch.
    logic              cur_we;
    logic [ADDR_W-1:0] cur_idx;
    logic [3:0]        cur_sel;
    logic [31:0]       cur_data;
    logic              cur_mis;

    logic [ADDR_W-1:0] idx_in;
    logic              accept;
    logic              commit;
    logic              in_idle;

    logic [31:0] mem [DEPTH];

    logic unused_ok;

    assign idx_in    = addr_i[ADDR_W+1:2];
    assign unused_ok = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign in_idle = (state == S_IDLE);
    assign accept  = in_idle && ce_i;

    // Completion happens on the edge that moves the FSM into DONE.
    assign commit  = (state_nxt == S_DONE);

    assign cur_we   = in_idle ? we_i   : we_q;
    assign cur_idx  = in_idle ? idx_in : idx_q;
    assign cur_sel  = in_idle ? sel_i  : sel_q;
    assign cur_data = in_idle ? data_i : wdata_q;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and stall
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall = ce_i;
                if (ce_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                // A request still held here is not re-accepted.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall is suppressed while reset is held.
    assign stall_o = stall && !rst_n;

    // ---------------------------------------------------------------
    // Request latch
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we_i;
            idx_q   <= idx_in;
            sel_q   <= sel_i;
            wdata_q <= data_i;
        end
    end

    // ---------------------------------------------------------------
    // Alignment check
    // ---------------------------------------------------------------
`ifdef DRAM_ALIGN_CHK_EN
    logic mis_in;
    logic mis_q;

    always_comb begin
        mis_in = 1'b0;
        if ((sel_i == 4'b1111) && (addr_i[1:0] != 2'b00)) begin
            mis_in = 1'b1;
        end
        if (((sel_i == 4'b1100) || (sel_i == 4'b0011)) && addr_i[0]) begin
            mis_in = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mis_q <= mis_in;
        end
    end

    assign cur_mis = in_idle ? mis_in : mis_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= commit && cur_mis;
        end
    end
`else
    assign cur_mis = 1'b0;
    assign err_o   = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Read data register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_o <= 32'd0;
        end else if (commit && !cur_we) begin
            // Reads always return the full word; sel is ignored.
            data_o <= cur_mis ? 32'd0 : mem[cur_idx];
        end
    end

    // ---------------------------------------------------------------
    // Array write port; contents survive reset, and a write that is
    // interrupted by reset is never committed.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n && commit && cur_we && !cur_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed scoreboard bench for data_ram_resp.
// Driver pushes hand-computed expectations; a monitor checks each completion.

module tb_data_ram_resp;

    localparam int AW = 10;
    localparam int WC = 1;

`ifdef DRAM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce    = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    logic [31:0] rdata0;
    logic        stall0;
    logic        err0;
    logic [31:0] rdata3;
    logic        stall3;
    logic        err3;

    always #5 clk = ~clk;

    data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce_i    (ce),
        .we_i    (we),
        .addr_i  (addr),
        .sel_i   (sel),
        .data_i  (wdata),
        .data_o  (rdata),
        .stall_o (stall),
        .err_o   (err)
    );

    data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce_i    (1'b1),
        .we_i    (1'b0),
        .addr_i  (32'h0),
        .sel_i   (4'hF),
        .data_i  (32'h0),
        .data_o  (rdata0),
        .stall_o (stall0),
        .err_o   (err0)
    );

    data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce_i    (1'b1),
        .we_i    (1'b0),
        .addr_i  (32'h0),
        .sel_i   (4'hF),
        .data_i  (32'h0),
        .data_o  (rdata3),
        .stall_o (stall3),
        .err_o   (err3)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          run;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: a completion is the first non-stalled cycle after a stall run.
    int   run = 0;
    exp_t me;

    always @(negedge clk) begin
        if (rst_n) begin
            run = 0;
        end else if (stall) begin
            run++;
        end else if (run > 0) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected completion: got data %h, want none",
                         rdata);
            end else begin
                me = sbq.pop_front();
                check({me.tag, " data"}, rdata, me.data);
                check({me.tag, " err"}, 32'(err), 32'(me.err));
                check({me.tag, " stall len"}, 32'(run), 32'(me.run));
            end
            run = 0;
        end
    end

    // Issue one access at posedge+1 and hold ce until completion.
    task automatic access(input string tag, input logic w,
                          input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input logic exp_e);
        exp_t e;
        int   cyc;
        bit   seen;
        bit   done;
        e.tag  = tag;
        e.data = exp_d;
        e.err  = exp_e;
        e.run  = 1 + WC;
        sbq.push_back(e);
        ce    = 1'b1;
        we    = w;
        addr  = a;
        sel   = s;
        wdata = d;
        cyc   = 0;
        seen  = 1'b0;
        done  = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stall) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no completion, want one in 40 cycles",
                     tag);
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    initial begin
        // Reset held with a request present: no stall, outputs cleared.
        rst_n = 1'b1;
        ce    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset data", rdata, 32'h0);
        check("reset err", 32'(err), 32'd0);
        check("reset stall wc0", 32'(stall0), 32'd0);
        check("reset stall wc3", 32'(stall3), 32'd0);
        @(posedge clk);
        #1;
        ce    = 1'b0;
        rst_n = 1'b0;

        // Continuous requests: 1,0 and 1,1,1,1,0 stall patterns.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("wc0 stall k%0d", k), 32'(stall0),
                  32'((k % 2) == 0));
            check($sformatf("wc3 stall k%0d", k), 32'(stall3),
                  32'((k % 5) != 4));
        end
        @(posedge clk);
        #1;

        // Full-word write then read back.
        access("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        access("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte-lane merge and sel=0000 write.
        access("wr20", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0);
        access("wr20b", 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 32'hDEADBEEF, 1'b0);
        access("rd20", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11AA3344, 1'b0);
        access("wr20z", 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h11AA3344, 1'b0);
        access("rd20z", 1'b0, 32'h20, 4'b0001, 32'h0, 32'h11AA3344, 1'b0);

        // Address wrap.
        access("wrwrap", 1'b1, 32'h1004, 4'hF, 32'hCAFEF00D, 32'h11AA3344, 1'b0);
        access("rdwrap", 1'b0, 32'h0004, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a write.
        access("wr40", 1'b1, 32'h40, 4'hF, 32'h12345678, 32'hCAFEF00D, 1'b0);
        access("rd40", 1'b0, 32'h40, 4'hF, 32'h0, 32'h12345678, 1'b0);
        ce    = 1'b1;
        we    = 1'b1;
        addr  = 32'h40;
        sel   = 4'hF;
        wdata = 32'h55555555;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ce    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst data", rdata, 32'h0);
        check("midrst stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        access("rd40post", 1'b0, 32'h40, 4'hF, 32'h0, 32'h12345678, 1'b0);

        // Misaligned full-word write and read.
        access("wr42", 1'b1, 32'h42, 4'hF, 32'h0BADBEEF, 32'h12345678, ALIGN);
        access("rd40al", 1'b0, 32'h40, 4'hF, 32'h0,
               ALIGN ? 32'h12345678 : 32'h0BADBEEF, 1'b0);
        access("rd42", 1'b0, 32'h42, 4'hF, 32'h0,
               ALIGN ? 32'h0 : 32'h0BADBEEF, ALIGN);

        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder for the core's RAM port: `ram_ce_o`/`ram_we_o`/`ram_addr_o`/`ram_sel_o`/`ram_data_o` arrive here, and `ram_data_i` is returned from here.
- Holds a word-organised on-chip array with byte-lane writes.
- Models a memory with configurable wait states, asserting a stall request to the pipeline until the access completes.
- Sits beside the core at the SoC top, opposite the core's mem stage.

Parameters:
- ADDR_W, 10, number of word-index bits; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra cycles between acceptance and completion; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1), name per codebase convention.
- ce_i  in  1  access request (from core `ram_ce_o`).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- sel_i  in  4  byte-lane enables; sel_i[3] = data[31:24] ... sel_i[0] = data[7:0].
- data_i  in  32  write data.
- data_o  out  32  read data (to core `ram_data_i`).
- stall_o  out  1  stall request to the pipeline controller.
- err_o  out  1  alignment-error pulse (see Optional Feature).

Behaviour:
- Word index = addr_i[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses alias (wrap). addr_i[1:0] does not affect the index.
- FSM states: IDLE, WAIT, DONE. A 4-bit down-counter cnt is used in WAIT.
- IDLE:
  - If ce_i=1: latch we/idx/sel/data_i.
  - Go to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to DONE.
  - stall_o = ce_i, combinational in IDLE only.
- WAIT:
  - stall_o=1.
  - When cnt=0, go to DONE; otherwise decrement cnt.
  - ce_i, addr_i and other inputs are ignored; the latched request is used.
- DONE:
  - Entered on the edge that completes the access.
  - On that edge, a write updates only the lanes with latched sel=1.
  - On that edge, a read registers data_o = mem[idx] as a full word; sel is ignored for reads.
  - A write leaves data_o unchanged.
  - stall_o=0 for exactly one cycle, then unconditional return to IDLE. A request still present in DONE is not re-accepted.
- Latency: stall_o is high for 1+WAIT_CYCLES consecutive cycles. data_o is valid in the DONE cycle and held until the next read completion.
- Back-to-back accesses: the minimum spacing between completions is WAIT_CYCLES+2 cycles.
- Write with sel=0000: the access runs its full timing and the array is unchanged.
- Reset (rst_n=1 on an edge):
  - state=IDLE, cnt=0, data_o=0, err_o=0.
  - stall_o follows the IDLE rule once reset deasserts; during reset stall_o=0.
  - Array contents are not cleared.
- Reset mid-access: a pending write is discarded (never committed) and a pending read is abandoned.

Optional Feature:
- Macro DRAM_ALIGN_CHK_EN.
- Defined:
  - In IDLE on acceptance, the access is misaligned if sel_i=1111 with addr_i[1:0]!=00, or if sel_i is 1100/0011 with addr_i[0]=1.
  - A misaligned access still runs the normal FSM timing.
  - Writes are suppressed (array unchanged). Reads return 0.
  - err_o pulses 1 for the DONE cycle.
- Undefined: err_o is tied to 0, no alignment check is made, and accesses proceed using the lane rules above.

Test Plan:
- WAIT_CYCLES=1: write addr 0x10, sel 1111, data 0xDEADBEEF, then read 0x10.
  - stall_o high 2 cycles per access.
  - data_o=0xDEADBEEF in the read's DONE cycle.
- Byte-lane merge: write 0x11223344 to 0x20, then write sel 0100 data 0x00AA0000, then read 0x20.
  - Expect 0x11AA3344.
  - Write sel 0000 data 0xFFFFFFFF, then read 0x20: still 0x11AA3344.
- Wrap, ADDR_W=10: write 0xCAFEF00D to 0x0000_1004, read 0x0000_0004.
  - Expect 0xCAFEF00D (aliasing).
- WAIT_CYCLES=0 and WAIT_CYCLES=3, continuous ce_i=1:
  - stall_o pattern 1,0,1,0… resp. 1,1,1,1,0 repeating.
  - No duplicate completion in DONE.
- Reset mid-write:
  - Write 0x55555555 to 0x40 (previously 0x12345678), assert rst_n during WAIT.
  - Next cycle data_o=0, stall_o=0; later read of 0x40 returns 0x12345678.
- With DRAM_ALIGN_CHK_EN, write sel 1111 to 0x42 data 0x0BADBEEF:
  - err_o=1 for one cycle.
  - Read of 0x40 unchanged.
  - Without the macro: err_o stays 0 and word 0x40 = 0x0BADBEEF.
